scalar_writeback_arbiter: RTL and testbench

// - Producer side of the scalar register file write port. Collects scalar results from ALU, LSU and

---
 rtl/scalar_writeback_arbiter_if.sv | 14 +
 rtl/scalar_writeback_arbiter.sv | 150 +++++++++++++++
 tb/tb_scalar_writeback_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_writeback_arbiter_if.sv
// Valid/ready result channel from one execution unit (ALU, LSU or V2S) into the
// scalar writeback arbiter. Master is the producing unit, slave is the arbiter.
interface scalar_writeback_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_W      = 5
);
    logic                  valid;
    logic                  ready;
    logic [REG_W-1:0]      rd;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output rd, output data, input ready);
    modport slave  (input valid, input rd, input data, output ready);
endinterface

// File: rtl/scalar_writeback_arbiter.sv
// Round-robin writeback arbiter for the scalar register file with a pending-write scoreboard.
// Optional wb-cycle forwarding of results to issue is enabled by defining SCALAR_WB_BYPASS_EN.
module scalar_writeback_arbiter #(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REGS   = 32,
    parameter int  MASK_REG   = 31,
    localparam int RW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_issue_valid,
    input  logic [RW-1:0]         i_issue_rd,
    input  logic [RW-1:0]         i_issue_rs1,
    input  logic [RW-1:0]         i_issue_rs2,
    output logic                  o_issue_stall,
    scalar_writeback_arbiter_if.slave alu_if,
    scalar_writeback_arbiter_if.slave lsu_if,
    scalar_writeback_arbiter_if.slave v2s_if,
    output logic                  o_wb_en,
    output logic [RW-1:0]         o_wb_rd,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_mask_update,
`ifdef SCALAR_WB_BYPASS_EN
    output logic                  o_byp_rs1_hit,
    output logic [DATA_WIDTH-1:0] o_byp_rs1_data,
    output logic                  o_byp_rs2_hit,
    output logic [DATA_WIDTH-1:0] o_byp_rs2_data,
`endif
    output logic [NUM_REGS-1:0]   o_pending_mask
);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_V2S = 2'd2
    } src_e;

    src_e                  r_ptr;
    logic                  r_wb_en;
    logic [RW-1:0]         r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_mask_update;
    logic [NUM_REGS-1:0]   r_pending;

    logic [2:0]            w_valid;
    logic [2:0]            w_grant;
    logic                  w_any;
    logic [1:0]            w_win;
    logic [1:0]            w_idx;
    src_e                  w_ptr_next;
    logic [RW-1:0]         w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NUM_REGS-1:0]   w_live;
    logic [NUM_REGS-1:0]   w_pending_next;
    logic                  w_issue_ok;

    assign w_valid = {v2s_if.valid, lsu_if.valid, alu_if.valid};

    // Scan the three sources starting at the pointer; first valid one wins.
    always_comb begin
        w_any = 1'b0;
        w_win = 2'd0;
        w_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            w_idx = 2'((int'(r_ptr) + k) % 3);
            if (!w_any && w_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_grant      = (w_any && !reset) ? (3'b001 << w_win) : 3'b000;
    assign alu_if.ready = w_grant[0];
    assign lsu_if.ready = w_grant[1];
    assign v2s_if.ready = w_grant[2];

    always_comb begin
        w_ptr_next = SRC_ALU;
        w_sel_rd   = v2s_if.rd;
        w_sel_data = v2s_if.data;
        case (w_win)
            2'd0: begin
                w_ptr_next = SRC_LSU;
                w_sel_rd   = alu_if.rd;
                w_sel_data = alu_if.data;
            end
            2'd1: begin
                w_ptr_next = SRC_V2S;
                w_sel_rd   = lsu_if.rd;
                w_sel_data = lsu_if.data;
            end
            default: w_ptr_next = SRC_ALU;
        endcase
    end

    // Register x0 is never a hazard; with forwarding, the entry being written this cycle is not either.
    always_comb begin
        w_live    = r_pending;
        w_live[0] = 1'b0;
`ifdef SCALAR_WB_BYPASS_EN
        if (r_wb_en) w_live[r_wb_rd] = 1'b0;
`endif
    end

    assign o_issue_stall = i_issue_valid &&
                           (w_live[i_issue_rs1] || w_live[i_issue_rs2] || w_live[i_issue_rd]);
    assign w_issue_ok    = i_issue_valid && !o_issue_stall;

    // Clear is applied first so a same-edge re-reservation of the index wins.
    always_comb begin
        w_pending_next = r_pending;
        if (r_wb_en) w_pending_next[r_wb_rd] = 1'b0;
        if (w_issue_ok && (i_issue_rd != '0)) w_pending_next[i_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= SRC_ALU;
            r_wb_en       <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_mask_update <= 1'b0;
            r_pending     <= '0;
        end else begin
            r_wb_en       <= w_any && (w_sel_rd != '0);
            r_mask_update <= w_any && (w_sel_rd == RW'(MASK_REG));
            if (w_any) begin
                r_ptr     <= w_ptr_next;
                r_wb_rd   <= w_sel_rd;
                r_wb_data <= w_sel_data;
            end
            r_pending <= w_pending_next;
        end
    end

    assign o_wb_en        = r_wb_en;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_mask_update  = r_mask_update;
    assign o_pending_mask = r_pending;

`ifdef SCALAR_WB_BYPASS_EN
    assign o_byp_rs1_hit  = r_wb_en && (r_wb_rd == i_issue_rs1) && (i_issue_rs1 != '0);
    assign o_byp_rs1_data = r_wb_data;
    assign o_byp_rs2_hit  = r_wb_en && (r_wb_rd == i_issue_rs2) && (i_issue_rs2 != '0);
    assign o_byp_rs2_data = r_wb_data;
`endif

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Scoreboard bench for scalar_writeback_arbiter: directed scenarios then randomized traffic,
// checked against a round-robin / pending-set reference model.
module tb_scalar_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mask_update;
    logic [31:0] pending_mask;
`ifdef SCALAR_WB_BYPASS_EN
    logic        byp_rs1_hit, byp_rs2_hit;
    logic [31:0] byp_rs1_data, byp_rs2_data;
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        src_valid [3];
    logic [4:0]  src_rd    [3];
    logic [31:0] src_data  [3];

    scalar_writeback_arbiter_if #(.DATA_WIDTH(32), .REG_W(5)) alu_bus ();
    scalar_writeback_arbiter_if #(.DATA_WIDTH(32), .REG_W(5)) lsu_bus ();
    scalar_writeback_arbiter_if #(.DATA_WIDTH(32), .REG_W(5)) v2s_bus ();

    assign alu_bus.valid = src_valid[0];
    assign alu_bus.rd    = src_rd[0];
    assign alu_bus.data  = src_data[0];
    assign lsu_bus.valid = src_valid[1];
    assign lsu_bus.rd    = src_rd[1];
    assign lsu_bus.data  = src_data[1];
    assign v2s_bus.valid = src_valid[2];
    assign v2s_bus.rd    = src_rd[2];
    assign v2s_bus.data  = src_data[2];

    wire [2:0] dut_ready = {v2s_bus.ready, lsu_bus.ready, alu_bus.ready};

    scalar_writeback_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .i_issue_valid  (issue_valid),
        .i_issue_rd     (issue_rd),
        .i_issue_rs1    (issue_rs1),
        .i_issue_rs2    (issue_rs2),
        .o_issue_stall  (issue_stall),
        .alu_if         (alu_bus),
        .lsu_if         (lsu_bus),
        .v2s_if         (v2s_bus),
        .o_wb_en        (wb_en),
        .o_wb_rd        (wb_rd),
        .o_wb_data      (wb_data),
        .o_mask_update  (mask_update),
`ifdef SCALAR_WB_BYPASS_EN
        .o_byp_rs1_hit  (byp_rs1_hit),
        .o_byp_rs1_data (byp_rs1_data),
        .o_byp_rs2_hit  (byp_rs2_hit),
        .o_byp_rs2_data (byp_rs2_data),
`endif
        .o_pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [4:0]  rd;
        bit [31:0] data;
        bit        mask;
        int        cyc;
    } wb_t;

    wb_t       expQ[$];
    int        checks   = 0;
    int        failures = 0;
    int        cycleNow = 0;
    bit        monOn    = 1'b0;

    bit [31:0] modelPending;
    int        modelPtr;
    bit        modelWbEn;
    bit [4:0]  modelWbRd;
    bit [31:0] modelWbData;

    always @(posedge clk) cycleNow = cycleNow + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cycleNow);
        end
    endtask

    function automatic bit liveHazard(input bit [4:0] x);
        bit h;
        h = modelPending[x] && (x != 5'd0);
        if (BYP && modelWbEn && (modelWbRd == x)) h = 1'b0;
        return h;
    endfunction

    // Each grant must appear on the write port exactly one cycle later.
    always @(negedge clk) begin
        if (monOn) begin
            while (expQ.size() != 0 && expQ[0].cyc < cycleNow - 1) begin
                checkOutput("wb_missing", 64'(expQ[0].rd), 64'h100);
                void'(expQ.pop_front());
            end
            if (wb_en === 1'b1) begin
                if (expQ.size() == 0 || expQ[0].cyc != cycleNow - 1) begin
                    checkOutput("wb_unexpected", 64'(wb_en), 64'd0);
                end else begin
                    wb_t e;
                    e = expQ.pop_front();
                    checkOutput("wb_rd", 64'(wb_rd), 64'(e.rd));
                    checkOutput("wb_data", 64'(wb_data), 64'(e.data));
                    checkOutput("mask_update", 64'(mask_update), 64'(e.mask));
                end
            end else begin
                checkOutput("wb_en_idle", 64'(wb_en), 64'd0);
                checkOutput("mask_idle", 64'(mask_update), 64'd0);
            end
        end
    end

    task automatic loadSrc(input int idx, input bit [4:0] rd, input bit [31:0] data);
        if (!src_valid[idx]) begin
            src_valid[idx] = 1'b1;
            src_rd[idx]    = rd;
            src_data[idx]  = data;
        end
    endtask

    // Called just after a rising edge with inputs set; model evaluates at the falling edge.
    task automatic applyStimulus();
        int       win;
        bit       wasReset;
        bit       stallExp;
        bit [31:0] nextPend;
        win      = -1;
        wasReset = reset;
        @(negedge clk);
        if (wasReset) begin
            checkOutput("ready_in_reset", 64'(dut_ready), 64'd0);
            modelPending = '0;
            modelPtr     = 0;
            modelWbEn    = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (modelPtr + k) % 3;
                if (win < 0 && src_valid[idx]) win = idx;
            end
            checkOutput("ready", 64'(dut_ready), (win < 0) ? 64'd0 : (64'd1 << win));
            checkOutput("pending_mask", 64'(pending_mask), 64'(modelPending));
            stallExp = issue_valid &&
                       (liveHazard(issue_rs1) || liveHazard(issue_rs2) || liveHazard(issue_rd));
            checkOutput("issue_stall", 64'(issue_stall), 64'(stallExp));
`ifdef SCALAR_WB_BYPASS_EN
            checkOutput("byp_rs1_hit", 64'(byp_rs1_hit),
                        64'(modelWbEn && modelWbRd == issue_rs1 && issue_rs1 != 0));
            checkOutput("byp_rs2_hit", 64'(byp_rs2_hit),
                        64'(modelWbEn && modelWbRd == issue_rs2 && issue_rs2 != 0));
            if (modelWbEn) checkOutput("byp_rs1_data", 64'(byp_rs1_data), 64'(modelWbData));
`endif
            nextPend = modelPending;
            if (modelWbEn) nextPend[modelWbRd] = 1'b0;
            if (issue_valid && !stallExp && issue_rd != 0) nextPend[issue_rd] = 1'b1;
            modelPending = nextPend;
            if (win >= 0) begin
                modelPtr    = (win + 1) % 3;
                modelWbEn   = (src_rd[win] != 0);
                modelWbRd   = src_rd[win];
                modelWbData = src_data[win];
                if (src_rd[win] != 0)
                    expQ.push_back('{rd: src_rd[win], data: src_data[win],
                                     mask: (src_rd[win] == 5'd31), cyc: cycleNow});
            end else begin
                modelWbEn = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (wasReset) begin
            for (int i = 0; i < 3; i++) src_valid[i] = 1'b0;
        end else if (win >= 0) begin
            src_valid[win] = 1'b0;
        end
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        issue_rs1   = 5'd0;
        issue_rs2   = 5'd0;
        reset       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    function automatic bit [4:0] pickReg();
        int r;
        r = $urandom_range(0, 8);
        return (r < 8) ? 5'(r) : 5'd31;
    endfunction

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        issue_rs1   = 5'd0;
        issue_rs2   = 5'd0;
        for (int i = 0; i < 3; i++) begin
            src_valid[i] = 1'b0;
            src_rd[i]    = 5'd0;
            src_data[i]  = 32'd0;
        end
        modelPending = '0;
        modelPtr     = 0;
        modelWbEn    = 1'b0;
        modelWbRd    = 5'd0;
        modelWbData  = 32'd0;

        @(posedge clk);
        #1;
        monOn = 1'b1;
        reset = 1'b1;
        applyStimulus();
        idle(1);

        // Single ALU result.
        loadSrc(0, 5'd5, 32'hDEADBEEF);
        applyStimulus();
        idle(2);

        // All three valid together from pointer=ALU.
        reset = 1'b1;
        applyStimulus();
        loadSrc(0, 5'd3, 32'h3333_0003);
        loadSrc(1, 5'd4, 32'h4444_0004);
        loadSrc(2, 5'd6, 32'h6666_0006);
        idle(4);

        // RAW hazard on rd=7 resolved by an LSU writeback granted in cycle 3.
        reset = 1'b1;
        applyStimulus();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        applyStimulus();
        for (int c = 1; c <= 6; c++) begin
            issue_valid = 1'b1;
            issue_rs1   = 5'd7;
            if (c == 3) loadSrc(1, 5'd7, 32'hCAFE_0007);
            #2;
            if (c == 1) checkOutput("stall_c1", 64'(issue_stall), 64'd1);
            if (c == 4) checkOutput("stall_c4", 64'(issue_stall), BYP ? 64'd0 : 64'd1);
            if (c == 5) checkOutput("stall_c5", 64'(issue_stall), 64'd0);
            applyStimulus();
        end

        // rd=0 result is accepted but never written.
        loadSrc(0, 5'd0, 32'h0000_1234);
        applyStimulus();
        idle(2);

        // Mask register write.
        loadSrc(2, 5'd31, 32'h0000_000F);
        applyStimulus();
        idle(2);

        // Reset arriving in the grant cycle squashes everything.
        issue_valid = 1'b1;
        issue_rd    = 5'd2;
        applyStimulus();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        applyStimulus();
        loadSrc(0, 5'd2, 32'hBAD0_0002);
        reset = 1'b1;
        applyStimulus();
        checkOutput("pending_after_reset", 64'(pending_mask), 64'd0);
        loadSrc(1, 5'd4, 32'h0000_0044);
        loadSrc(0, 5'd3, 32'h0000_0033);
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) reset = 1'b1;
            for (int i = 0; i < 3; i++)
                if (!src_valid[i] && $urandom_range(0, 1) == 1) loadSrc(i, pickReg(), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                issue_valid = 1'b1;
                issue_rd    = pickReg();
                issue_rs1   = pickReg();
                issue_rs2   = pickReg();
            end
            applyStimulus();
        end

        idle(10);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
